// File: rtl/rst_ckpt.sv
// Register status table: maps each architectural register to the ROB tag of its
// pending producer, with CDB clear, $0 protection, flush and branch checkpoints.
module rst_ckpt #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned NCKPT      = 4,
  parameter int unsigned CDB_BYPASS = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [$clog2(NREG)-1:0]   Rsaddr_rst,
  output logic [TAG_W-1:0]          Rstag_rst,
  output logic                      Rsvalid_rst,
  input  logic [$clog2(NREG)-1:0]   Rtaddr_rst,
  output logic [TAG_W-1:0]          Rttag_rst,
  output logic                      Rtvalid_rst,
  input  logic                      Wen_rst,
  input  logic [$clog2(NREG)-1:0]   Waddr_rst,
  input  logic [TAG_W-1:0]          Wdata_rst,
  input  logic                      RB_valid_rst,
  input  logic [TAG_W-1:0]          RB_tag_rst,
  input  logic                      Ckpt_req_rst,
  output logic                      Ckpt_ok_rst,
  output logic [$clog2(NCKPT)-1:0]  Ckpt_id_rst,
  input  logic                      Ckpt_release_rst,
  input  logic                      Restore_rst,
  input  logic [$clog2(NCKPT)-1:0]  Restore_id_rst,
  input  logic                      Flush_rst,
  output logic                      Ckpt_full_rst,
  output logic                      Ckpt_empty_rst,
  output logic [NREG-1:0]           Busy_rst
);

  localparam int unsigned CW = $clog2(NCKPT);
  localparam int unsigned PW = CW + 1;

  logic [NREG-1:0]  vld_q, vld_d, clr_vld;
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];
  logic [TAG_W-1:0] clr_tag [NREG];

  logic [NREG-1:0]  ck_vld_q [NCKPT];
  logic [NREG-1:0]  ck_vld_d [NCKPT];
  logic [TAG_W-1:0] ck_tag_q [NCKPT][NREG];
  logic [TAG_W-1:0] ck_tag_d [NCKPT][NREG];

  logic [PW-1:0]    head_q, tail_q, head_d, tail_d;
  logic [CW-1:0]    rst_off;
  logic             full_c, empty_c, rs_byp, rt_byp;

  // Checkpoint ring status; the extra pointer bit tells full from empty
  assign full_c         = (head_q[CW] != tail_q[CW]) && (head_q[CW-1:0] == tail_q[CW-1:0]);
  assign empty_c        = (head_q == tail_q);
  assign Ckpt_full_rst  = full_c;
  assign Ckpt_empty_rst = empty_c;
  assign Ckpt_ok_rst    = Ckpt_req_rst & ~full_c & ~Restore_rst & ~Flush_rst;
  assign Ckpt_id_rst    = tail_q[CW-1:0];
  assign Busy_rst       = vld_q;
  assign rst_off        = Restore_id_rst - head_q[CW-1:0];

  // Reads come from registered state; a live CDB match hides the pending bit
  assign rs_byp      = (CDB_BYPASS != 0) && RB_valid_rst && (tag_q[Rsaddr_rst] == RB_tag_rst);
  assign rt_byp      = (CDB_BYPASS != 0) && RB_valid_rst && (tag_q[Rtaddr_rst] == RB_tag_rst);
  assign Rstag_rst   = tag_q[Rsaddr_rst];
  assign Rsvalid_rst = vld_q[Rsaddr_rst] & ~rs_byp;
  assign Rttag_rst   = tag_q[Rtaddr_rst];
  assign Rtvalid_rst = vld_q[Rtaddr_rst] & ~rt_byp;

  always_comb begin
    clr_vld = vld_q;
    for (int i = 0; i < NREG; i++) begin
      clr_tag[i] = tag_q[i];
      if (RB_valid_rst && vld_q[i] && (tag_q[i] == RB_tag_rst)) begin
        clr_vld[i] = 1'b0;
        clr_tag[i] = '0;
      end
    end

    // Snapshots retire tags on the CDB just like the live table
    for (int s = 0; s < NCKPT; s++) begin
      ck_vld_d[s] = ck_vld_q[s];
      for (int i = 0; i < NREG; i++) begin
        ck_tag_d[s][i] = ck_tag_q[s][i];
        if (RB_valid_rst && ck_vld_q[s][i] && (ck_tag_q[s][i] == RB_tag_rst)) begin
          ck_vld_d[s][i] = 1'b0;
          ck_tag_d[s][i] = '0;
        end
      end
    end

    vld_d  = clr_vld;
    tag_d  = clr_tag;
    head_d = head_q;
    tail_d = tail_q;

    if (Flush_rst) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
      for (int i = 0; i < NREG; i++) tag_d[i] = '0;
      for (int s = 0; s < NCKPT; s++) begin
        ck_vld_d[s] = '0;
        for (int i = 0; i < NREG; i++) ck_tag_d[s][i] = '0;
      end
    end else if (Restore_rst) begin
      vld_d = ck_vld_d[Restore_id_rst];
      tag_d = ck_tag_d[Restore_id_rst];
      // Restoring the head slot empties the ring and swallows any release
      if (rst_off == '0) begin
        tail_d = head_q;
      end else begin
        head_d = head_q + PW'(Ckpt_release_rst);
        tail_d = head_q + PW'(rst_off);
      end
    end else begin
      // Snapshot excludes this cycle's rename, which belongs to the younger path
      if (Ckpt_ok_rst) begin
        ck_vld_d[tail_q[CW-1:0]] = clr_vld;
        ck_tag_d[tail_q[CW-1:0]] = clr_tag;
        tail_d = tail_q + PW'(1);
      end
      if (Ckpt_release_rst && !empty_c) head_d = head_q + PW'(1);
      if (Wen_rst && (Waddr_rst != '0)) begin
        vld_d[Waddr_rst] = 1'b1;
        tag_d[Waddr_rst] = Wdata_rst;
      end
    end

    vld_d[0] = 1'b0;
    tag_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
      for (int s = 0; s < NCKPT; s++) begin
        ck_vld_q[s] <= '0;
        for (int i = 0; i < NREG; i++) ck_tag_q[s][i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      ck_vld_q <= ck_vld_d;
      ck_tag_q <= ck_tag_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // A restore must name a live checkpoint
  a_restore_live: assert property (@(posedge clock) disable iff (!reset)
      (Restore_rst && !Flush_rst) |-> (PW'(rst_off) < PW'(tail_q - head_q)))
    else $error("restore id outside live checkpoint range");

endmodule

// File: doc/rst_ckpt.md
Name: rst_ckpt

Overview:
- Parametrised register status table for the Tomasulo/ROB MIPS core. Maps each architectural register to the ROB tag of its pending producer, with a valid bit.
- Sits between decode/dispatch and the ROB/CDB.
- Adds the following over the first-generation table: configurable size, CDB read bypass, $0 protection, full flush, and a circular stack of branch checkpoints with restore on mispredict.

Parameters:
- NREG, 32: architectural registers; AW = clog2(NREG).
- TAG_W, 5: ROB tag width.
- NCKPT, 4: checkpoint slots (power of 2); CW = clog2(NCKPT).
- CDB_BYPASS, 1: when 1, reads see the same-cycle CDB clear.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: synchronous, active-low.
- Rsaddr_rst in AW: Rs read address.
- Rstag_rst out TAG_W: Rs producer tag.
- Rsvalid_rst out 1: Rs pending.
- Rtaddr_rst in AW: Rt read address.
- Rttag_rst out TAG_W: Rt producer tag.
- Rtvalid_rst out 1: Rt pending.
- Wen_rst in 1: rename write.
- Waddr_rst in AW: rename destination.
- Wdata_rst in TAG_W: new tag.
- RB_valid_rst in 1: CDB broadcast valid.
- RB_tag_rst in TAG_W: CDB tag.
- Ckpt_req_rst in 1: take checkpoint.
- Ckpt_ok_rst out 1: checkpoint accepted this cycle.
- Ckpt_id_rst out CW: slot id allocated when Ckpt_ok_rst=1.
- Ckpt_release_rst in 1: oldest branch resolved correct; free head slot.
- Restore_rst in 1: mispredict.
- Restore_id_rst in CW: slot to restore.
- Flush_rst in 1: clear all state.
- Ckpt_full_rst out 1: all slots in use.
- Ckpt_empty_rst out 1: no slots in use.
- Busy_rst out NREG: per-register valid bits, registered.

Behaviour:

Reset
- Synchronous, active-low. Clears all entries to {0,0}, all slots, and head/tail pointers.
- Ckpt_empty_rst=1; Ckpt_full_rst=0; Busy_rst=0; Ckpt_ok_rst=0 (input-gated).

Entry and CDB clear
- Entry = {valid, tag}.
- CDB clear: every entry with valid=1 and tag==RB_tag_rst is cleared when RB_valid_rst=1.
- Entries being written this cycle are excluded from the clear; the write wins.
- Wen_rst with Waddr_rst=0 is ignored. Entry 0 is constantly {0,0}.

Reads
- Combinational from registered state.
- If CDB_BYPASS=1 and the read entry matches the live CDB tag, valid reads 0.
- No write-to-read bypass: a same-cycle rename is visible next cycle.

Checkpoints
- Circular buffer with (CW+1)-bit head/tail pointers. full = MSBs differ and LSBs equal; empty = pointers equal.
- Ckpt_ok_rst = Ckpt_req_rst & ~full & ~Restore_rst & ~Flush_rst.
- Ckpt_id_rst = tail[CW-1:0].
- On ok, slot[tail] captures the current table with this cycle's CDB clear applied and without this cycle's Wen_rst (that write belongs to the younger path). tail increments.
- Every valid slot also applies the CDB clear each cycle, so snapshots never hold retired tags.
- Ckpt_release_rst increments head when not empty; it is ignored when empty.

Restore (Restore_rst=1)
- Table <= slot[Restore_id_rst] with the same-cycle CDB clear applied.
- tail <= the pointer value equal to Restore_id_rst, freeing that slot and all younger ones.
- Wen_rst and Ckpt_req_rst are ignored that cycle.
- Same-cycle release: head still advances. If Restore_id_rst equals the head slot, the release is ignored and the buffer becomes empty.
- Restore_id_rst outside [head, tail) is illegal; it is flagged by assertion and behaviour is undefined.

Priority, highest first
- reset > Flush_rst > Restore_rst > (Wen_rst, CDB clear, checkpoint take/release).
- Flush_rst clears the table and all slots and sets head=tail=0.

Latency
- All state updates are visible on outputs the cycle after the clock edge.
- Busy_rst reflects the registered table.

Test Plan:
- Reset low 2 cycles with random inputs, then release → Busy_rst=0, Ckpt_empty_rst=1; all reads return {0,0}.
- Wen r5 tag 7; next cycle Rsaddr=5 → Rsvalid=1, Rstag=7. Then RB_valid tag 7 with CDB_BYPASS=1 → Rsvalid=0 same cycle; entry cleared next cycle. Wen r3 tag 9 together with CDB tag 9 on old r3 → r3 reads {1,9}.
- Wen r0 tag 4 → Busy_rst[0]=0. Wen r8 tag 2 and CDB tag 2 in the same cycle on the same register → r8={1,2}.
- Take 4 checkpoints (NCKPT=4) → ids 0,1,2,3; Ckpt_full_rst=1. 5th request → Ckpt_ok_rst=0 and no state change. Release → Ckpt_full_rst=0.
- r6 tag 1; checkpoint id0; Wen r6 tag 3; CDB tag 1 broadcast; Restore id0 → r6={0,0} (snapshot was cleared by CDB); tail=head; Ckpt_empty_rst=1.
- Restore with simultaneous Wen_rst and Ckpt_req_rst → write dropped, Ckpt_ok_rst=0. Flush_rst mid-sequence with 2 slots live → table clear, empty=1. Reset asserted the same cycle as Flush_rst → reset state.
